rmii_rx_frame: RTL and testbench

RMII receive framer for an Ethernet PHY port. It samples the 2-bit RMII receive bus on the 50 MHz reference clock, strips the preamble and SFD, and assembles dibits into bytes, LSB dibit first. It delivers a byte stream with start-of-frame and end-of-frame markers, frame length and error status to the downstream MAC/packet-buffer logic in `top`. There is one instance per PHY port (`_1`, `_2`).

---
 rtl/rmii_rx_frame.sv | 205 ++++++++++++++++++++
 tb/tb_rmii_rx_frame.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_frame.sv
// rmii_rx_frame: RMII receive framer; strips preamble/SFD and delivers bytes with sof/eof and frame status.
// Define RMII_RX_CRC_CHECK_EN to check the FCS; otherwise crc_ok reads 1 after every frame.
module rmii_rx_frame #(
    parameter int MAX_LEN = 1522
) (
    input  logic        clk_50_mhz,
    input  logic        rst,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        sof,
    output logic        eof,
    output logic [10:0] frame_len,
    output logic        err_rx,
    output logic        err_align,
    output logic        err_len,
    output logic        crc_ok
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state_q, state_d;
    logic        crs_q, er_q, post_rst_q;
    logic [1:0]  rxd_q;
    logic        seen01_q, seen01_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [5:0]  sh_q, sh_d;
    logic [7:0]  hold_q, hold_d;
    logic        have_q, have_d, first_q, first_d, acc_q, acc_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  dout_q, dout_d;
    logic        dv_q, dv_d, sof_q, sof_d, eof_q, eof_d;
    logic [10:0] flen_q, flen_d;
    logic        erx_q, erx_d, eal_q, eal_d, elen_q, elen_d, crcok_q, crcok_d;
    logic [7:0]  byte_w;
    logic        crc_match;

`ifdef RMII_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    assign crc_match = (crc_q == 32'hDEBB20E3);
`else
    assign crc_match = 1'b1;
`endif

    // Dibits shift in from the top, so after three of them the fourth completes the byte.
    assign byte_w = {rxd_q, sh_q};

    always_comb begin
        state_d  = state_q;
        seen01_d = seen01_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        hold_d   = hold_q;
        have_d   = have_q;
        first_d  = first_q;
        acc_d    = acc_q;
        len_d    = len_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        flen_d   = flen_q;
        erx_d    = erx_q;
        eal_d    = eal_q;
        elen_d   = elen_q;
        crcok_d  = crcok_q;
`ifdef RMII_RX_CRC_CHECK_EN
        crc_d    = crc_q;
`endif
        case (state_q)
            IDLE: begin
                seen01_d = 1'b0;
                if (post_rst_q && crs_dv) state_d = DROP;
                else if (crs_q) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                if (!crs_q) state_d = IDLE;
                else if (rxd_q == 2'b01) seen01_d = 1'b1;
                else if (rxd_q == 2'b10) state_d = DROP;
                else if (rxd_q == 2'b11) begin
                    state_d = seen01_q ? DATA : DROP;
                    cnt_d   = 2'd0;
                    have_d  = 1'b0;
                    first_d = 1'b1;
                    acc_d   = 1'b0;
                    len_d   = 11'd0;
`ifdef RMII_RX_CRC_CHECK_EN
                    crc_d   = 32'hFFFFFFFF;
`endif
                end
            end
            DATA: begin
                acc_d = acc_q | er_q;
                if (crs_q) begin
                    cnt_d = cnt_q + 2'd1;
                    sh_d  = {rxd_q, sh_q[5:2]};
                    if (cnt_q == 2'd3) begin
                        hold_d = byte_w;
                        have_d = 1'b1;
                        len_d  = (&len_q) ? len_q : len_q + 11'd1;
`ifdef RMII_RX_CRC_CHECK_EN
                        crc_d  = crc_next(crc_q, byte_w);
`endif
                        if (have_q) begin
                            dv_d    = 1'b1;
                            dout_d  = hold_q;
                            sof_d   = first_q;
                            first_d = 1'b0;
                        end
                    end
                end else begin
                    state_d = IDLE;
                    if (have_q) begin
                        dv_d    = 1'b1;
                        dout_d  = hold_q;
                        sof_d   = first_q;
                        eof_d   = 1'b1;
                        flen_d  = len_q;
                        erx_d   = acc_q | er_q;
                        eal_d   = (cnt_q != 2'd0);
                        elen_d  = (len_q > 11'(MAX_LEN));
                        crcok_d = crc_match;
                    end
                end
            end
            DROP: if (!crs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50_mhz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            crs_q      <= 1'b0;
            er_q       <= 1'b0;
            rxd_q      <= 2'b00;
            post_rst_q <= 1'b1;
            seen01_q   <= 1'b0;
            cnt_q      <= 2'd0;
            sh_q       <= 6'd0;
            hold_q     <= 8'd0;
            have_q     <= 1'b0;
            first_q    <= 1'b0;
            acc_q      <= 1'b0;
            len_q      <= 11'd0;
            dout_q     <= 8'd0;
            dv_q       <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            flen_q     <= 11'd0;
            erx_q      <= 1'b0;
            eal_q      <= 1'b0;
            elen_q     <= 1'b0;
            crcok_q    <= 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
            crc_q      <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q    <= state_d;
            crs_q      <= crs_dv;
            er_q       <= rx_er;
            rxd_q      <= rx_d;
            post_rst_q <= 1'b0;
            seen01_q   <= seen01_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            have_q     <= have_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            flen_q     <= flen_d;
            erx_q      <= erx_d;
            eal_q      <= eal_d;
            elen_q     <= elen_d;
            crcok_q    <= crcok_d;
`ifdef RMII_RX_CRC_CHECK_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign frame_len  = flen_q;
    assign err_rx     = erx_q;
    assign err_align  = eal_q;
    assign err_len    = elen_q;
    assign crc_ok     = crcok_q;
endmodule

// File: tb/tb_rmii_rx_frame.sv
// tb_rmii_rx_frame: directed frames into rmii_rx_frame with hand-computed byte, flag and latency expectations.
module tb_rmii_rx_frame;
`ifdef RMII_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam logic [31:0] MASK = 32'h77FF;

    logic        clk = 1'b0, rst = 1'b1, crs_dv = 1'b0, rx_er = 1'b0;
    logic [1:0]  rx_d = 2'b00;
    logic [7:0]  data_out;
    logic        data_valid, sof, eof, err_rx, err_align, err_len, crc_ok;
    logic [10:0] frame_len;

    rmii_rx_frame dut (
        .clk_50_mhz(clk), .rst(rst), .crs_dv(crs_dv), .rx_d(rx_d), .rx_er(rx_er),
        .data_out(data_out), .data_valid(data_valid), .sof(sof), .eof(eof),
        .frame_len(frame_len), .err_rx(err_rx), .err_align(err_align),
        .err_len(err_len), .crc_ok(crc_ok)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  tx[$];
    logic [31:0] got_b[$], sof_at[$], eof_at[$], dv_cyc[$], e_info[$];
    int          stray = 0, checks = 0, passed = 0, t_b1 = 0, t_drop = 0;
    logic [31:0] crc, fcs;

    // info word: {err_rx, err_align, err_len, crc_ok, frame_len}
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            if (sof) sof_at.push_back(got_b.size());
            if (eof) begin
                eof_at.push_back(got_b.size());
                e_info.push_back({17'b0, err_rx, err_align, err_len, crc_ok, frame_len});
            end
            dv_cyc.push_back(cyc);
            got_b.push_back(32'(data_out));
        end
        if (!rst && (sof || eof) && !data_valid) stray++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    task automatic clr();
        got_b.delete(); sof_at.delete(); eof_at.delete(); dv_cyc.delete(); e_info.delete();
    endtask

    task automatic put(input logic c, input logic [1:0] d, input logic e);
        @(posedge clk);
        #1;
        crs_dv = c;
        rx_d   = d;
        rx_er  = e;
    endtask

    task automatic send(input int npre, input int bad_at, input int extra, input int er_at,
                        input int rst_at, input int gap);
        int k;
        k = 0;
        for (int i = 0; i < npre; i++) put(1'b1, (i == bad_at) ? 2'b10 : 2'b01, 1'b0);
        put(1'b1, 2'b11, 1'b0);
        for (int b = 0; b < tx.size(); b++) begin
            for (int j = 0; j < 4; j++) begin
                put(1'b1, tx[b][2*j +: 2], k == er_at);
                if (b == 1 && j == 3) t_b1 = cyc;
                if (k == rst_at) begin
                    rst = 1'b1;
                    #1;
                    check("rst_outputs_zero", {6'b0, data_out, data_valid, sof, eof, frame_len,
                          err_rx, err_align, err_len, crc_ok}, 32'h0);
                    clr();
                end
                if (k == rst_at + 2) rst = 1'b0;
                k++;
            end
        end
        for (int i = 0; i < extra; i++) put(1'b1, 2'b00, 1'b0);
        put(1'b0, 2'b00, 1'b0);
        t_drop = cyc;
        for (int i = 1; i < gap; i++) put(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        #1;
        check("reset_outputs", {6'b0, data_out, data_valid, sof, eof, frame_len,
              err_rx, err_align, err_len, crc_ok}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) put(1'b0, 2'b00, 1'b0);

        clr();
        tx = '{8'h12, 8'h34, 8'h56};
        send(7, -1, 0, -1, -1, 6);
        check("short_count", got_b.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("short_b%0d", i), qv(got_b, i), 32'(tx[i]));
        check("short_nsof", sof_at.size(), 1);
        check("short_sof_pos", qv(sof_at, 0), 0);
        check("short_eof_pos", qv(eof_at, 0), 2);
        check("short_info", qv(e_info, 0) & MASK, 32'd3);
        check("short_lat_first", qv(dv_cyc, 0), 32'(t_b1 + 2));
        check("short_lat_eof", qv(dv_cyc, 2), 32'(t_drop + 2));

        clr();
        tx.delete();
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            tx.push_back(8'(i * 3 + 1));
            crc = crc_byte(crc, 8'(i * 3 + 1));
        end
        fcs = ~crc;
        for (int i = 0; i < 4; i++) tx.push_back(fcs[8*i +: 8]);
        send(31, -1, 0, -1, -1, 6);
        check("full_count", got_b.size(), 64);
        check("full_last_byte", qv(got_b, 63), 32'(fcs[31:24]));
        check("full_info_crc_good", qv(e_info, 0), {17'b0, 4'b0001, 11'd64});
        clr();
        tx[61] = tx[61] ^ 8'h04;
        send(31, -1, 0, -1, -1, 6);
        check("full_info_crc_bad", qv(e_info, 0), {17'b0, 3'b000, !CRC_EN, 11'd64});

        clr();
        tx = '{8'h12};
        send(7, -1, 2, -1, -1, 6);
        check("trail_count", got_b.size(), 1);
        check("trail_byte", qv(got_b, 0), 32'h12);
        check("trail_sof_pos", qv(sof_at, 0), 0);
        check("trail_eof_pos", qv(eof_at, 0), 0);
        check("trail_info", qv(e_info, 0) & MASK, 32'h2001);

        clr();
        tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(7, -1, 0, 5, -1, 6);
        check("rxer_count", got_b.size(), 4);
        check("rxer_info", qv(e_info, 0) & MASK, 32'h4004);

        clr();
        tx = '{8'h12, 8'h34, 8'h56};
        send(7, 3, 0, -1, -1, 6);
        check("false_carrier_bytes", got_b.size(), 0);
        check("false_carrier_eofs", e_info.size(), 0);
        tx = '{8'h9A, 8'hBC};
        send(7, -1, 0, -1, -1, 6);
        check("after_fc_count", got_b.size(), 2);
        check("after_fc_b1", qv(got_b, 1), 32'hBC);
        check("after_fc_info", qv(e_info, 0) & MASK, 32'd2);

        clr();
        tx.delete();
        for (int i = 0; i < 1600; i++) tx.push_back(8'(i));
        send(7, -1, 0, -1, -1, 1);
        tx = '{8'hA1, 8'hA2, 8'hA3};
        send(7, -1, 0, -1, -1, 6);
        check("big_count", got_b.size(), 1603);
        check("big_byte_1599", qv(got_b, 1599), 32'h3F);
        check("big_neofs", e_info.size(), 2);
        check("big_info", qv(e_info, 0) & MASK, 32'h1640);
        check("b2b_sof_pos", qv(sof_at, 1), 1600);
        check("b2b_last_byte", qv(got_b, 1602), 32'hA3);
        check("b2b_info", qv(e_info, 1) & MASK, 32'd3);

        check("pre_rst_len", 32'(frame_len), 32'd3);
        clr();
        tx = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send(7, -1, 0, -1, 20, 6);
        check("rst_frame_bytes", got_b.size(), 0);
        check("rst_frame_eofs", e_info.size(), 0);
        clr();
        tx = '{8'h55, 8'h66, 8'h77};
        send(7, -1, 0, -1, -1, 6);
        check("post_rst_count", got_b.size(), 3);
        check("post_rst_b0", qv(got_b, 0), 32'h55);
        check("post_rst_info", qv(e_info, 0) & MASK, 32'd3);

        check("no_stray_flags", stray, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
